// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO between the CPU UART data register and the
// UART emitter, with a SEND/HOLD/IDLE presenter and a status word.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wrData,
  input  logic              wrValid,
  input  logic              flush,
  input  logic              clrOverflow,
  output logic [7:0]        txData,
  output logic              txValid,
  input  logic              txReady,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [31:0]       ctrlRData
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_e;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop;
  logic [7:0]        cnt8;

  assign txValid  = (state_q == SEND);
  assign txData   = txValid ? mem_q[rd_ptr_q] : 8'h00;
  assign count    = count_q;
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;

  assign pop  = txValid & txReady;
  assign push = wrValid & ~flush & (~full | pop);
  assign drop = wrValid & ~flush & full & ~pop;

  assign cnt8      = 8'(count_q);
  assign ctrlRData = {8'h00, cnt8, 4'h0,
                      txValid, ovf_q, full, empty,
                      8'h00};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // a drop in the same cycle beats the clear
    if (drop)             ovf_d = 1'b1;
    else if (clrOverflow) ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && !flush) state_d = SEND;
      end
      SEND: begin
        if (flush)    state_d = IDLE;
        else if (pop) state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wrData;
  end

endmodule
